// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and FSM encoding for the alu accumulator sequencer
package alu_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] KIND_EXEC = 2'b00;
  localparam logic [1:0] KIND_LOAD = 2'b01;
  localparam logic [1:0] KIND_CLRF = 2'b10;
  localparam logic [1:0] KIND_READ = 2'b11;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_acc_seq.sv
// rtl/alu_acc_seq.sv - command-driven accumulator sequencer feeding an external combinational alu
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_mode,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic             cmd_use_cf,
  input  logic             cmd_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_c_in,
  output logic             alu_mode,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cf,
  output logic             rsp_zf,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic             cf_q;
  logic             zf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             mode_q;
  logic             cin_q;
  logic             accept;

  assign accept = cmd_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = (cmd_kind == KIND_EXEC) ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      mode_q  <= MODE_LOGIC;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Snapshot the accumulator too so every alu input is a flop during EXEC.
        a_q    <= acc_q;
        b_q    <= cmd_operand;
        op_q   <= cmd_op;
        mode_q <= cmd_mode;
        cin_q  <= cmd_use_cf ? cf_q : cmd_cin;
        case (cmd_kind)
          KIND_LOAD: begin
            acc_q <= cmd_operand;
            zf_q  <= (cmd_operand == '0);
          end
          KIND_CLRF: begin
            cf_q <= 1'b0;
          end
          default: begin
          end
        endcase
      end
      if (state_q == ST_EXEC) begin
        acc_q <= alu_out;
        zf_q  <= (alu_out == '0);
        // Logic-mode carry out is meaningless; keep the chained carry intact.
        if (mode_q == MODE_ARITH) begin
          cf_q <= alu_c_out;
        end
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign alu_mode = mode_q;
  assign alu_c_in = cin_q;
  assign rsp_data = acc_q;
  assign rsp_cf   = cf_q;
  assign rsp_zf   = zf_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// tb/tb_alu_acc_seq.sv - directed self-checking bench for alu_acc_seq with a stub alu
module tb_alu_acc_seq;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_kind;
  logic [2:0]       cmd_op;
  logic             cmd_mode;
  logic [WIDTH-1:0] cmd_operand;
  logic             cmd_use_cf;
  logic             cmd_cin;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_c_in;
  logic             alu_mode;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_c_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cf;
  logic             rsp_zf;
  logic [CNT_W-1:0] op_count;

  int n_checks;
  int n_fail;
  int lat;

  alu_acc_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_operand(cmd_operand),
    .cmd_use_cf(cmd_use_cf), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_mode(alu_mode),
    .alu_op(alu_op), .alu_out(alu_out), .alu_c_out(alu_c_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .op_count(op_count)
  );

  // Stub alu: arith op 000 is A+B+c_in, logic op 000 is A&B with no carry.
  always_comb begin
    alu_out   = '0;
    alu_c_out = 1'b0;
    if (alu_mode && alu_op == 3'b000) begin
      {alu_c_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_c_in};
    end else if (!alu_mode && alu_op == 3'b000) begin
      alu_out = alu_a & alu_b;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command, wait for acceptance, and return cycles from accept to rsp_valid.
  task automatic do_cmd(input logic [1:0] kind, input logic [2:0] op, input logic mode,
                        input logic [3:0] operand, input logic use_cf, input logic cin,
                        output int cycles);
    int waited;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_kind    = kind;
    cmd_op      = op;
    cmd_mode    = mode;
    cmd_operand = operand;
    cmd_use_cf  = use_cf;
    cmd_cin     = cin;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cycles = 1;
    while (!rsp_valid && cycles < 10) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!rsp_valid) check("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic exec_add(input logic [3:0] operand, input logic use_cf, input logic cin);
    do_cmd(2'b00, 3'b000, 1'b1, operand, use_cf, cin, lat);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_kind    = 2'b00;
    cmd_op      = 3'b000;
    cmd_mode    = 1'b0;
    cmd_operand = 4'h0;
    cmd_use_cf  = 1'b0;
    cmd_cin     = 1'b0;
    rsp_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("reset_alu_a", {28'b0, alu_a}, 32'd0);

    // LOAD A then EXEC add 3 -> D
    do_cmd(2'b01, 3'b000, 1'b0, 4'hA, 1'b0, 1'b0, lat);
    check("load_latency", lat, 32'd1);
    check("load_data", {28'b0, rsp_data}, 32'hA);
    finish_rsp();
    exec_add(4'h3, 1'b0, 1'b0);
    check("exec_latency", lat, 32'd2);
    check("add_data", {28'b0, rsp_data}, 32'hD);
    check("add_cf", {31'b0, rsp_cf}, 32'd0);
    check("add_zf", {31'b0, rsp_zf}, 32'd0);
    check("add_count", {24'b0, op_count}, 32'd1);
    finish_rsp();

    // F+1 wraps to 0 with carry, then chain the carry into 0+0
    do_cmd(2'b01, 3'b000, 1'b0, 4'hF, 1'b0, 1'b0, lat);
    finish_rsp();
    exec_add(4'h1, 1'b0, 1'b0);
    check("wrap_data", {28'b0, rsp_data}, 32'h0);
    check("wrap_cf", {31'b0, rsp_cf}, 32'd1);
    check("wrap_zf", {31'b0, rsp_zf}, 32'd1);
    finish_rsp();
    exec_add(4'h0, 1'b1, 1'b0);
    check("chain_data", {28'b0, rsp_data}, 32'h1);
    check("chain_cf", {31'b0, rsp_cf}, 32'd0);
    check("chain_zf", {31'b0, rsp_zf}, 32'd0);
    finish_rsp();

    // Logic-mode AND keeps cf, then CLRF clears it
    do_cmd(2'b01, 3'b000, 1'b0, 4'hF, 1'b0, 1'b0, lat);
    finish_rsp();
    exec_add(4'h1, 1'b0, 1'b0);
    finish_rsp();
    do_cmd(2'b01, 3'b000, 1'b0, 4'hA, 1'b0, 1'b0, lat);
    check("load_keeps_cf", {31'b0, rsp_cf}, 32'd1);
    finish_rsp();
    do_cmd(2'b00, 3'b000, 1'b0, 4'h5, 1'b0, 1'b0, lat);
    check("and_data", {28'b0, rsp_data}, 32'h0);
    check("and_zf", {31'b0, rsp_zf}, 32'd1);
    check("and_cf_kept", {31'b0, rsp_cf}, 32'd1);
    finish_rsp();
    do_cmd(2'b10, 3'b000, 1'b0, 4'h0, 1'b0, 1'b0, lat);
    check("clrf_cf", {31'b0, rsp_cf}, 32'd0);
    check("clrf_data", {28'b0, rsp_data}, 32'h0);
    check("clrf_latency", lat, 32'd1);
    finish_rsp();

    // Reset in the middle of a RESP with nonzero state
    do_cmd(2'b01, 3'b000, 1'b0, 4'hF, 1'b0, 1'b0, lat);
    finish_rsp();
    exec_add(4'h1, 1'b0, 1'b0);
    finish_rsp();
    do_cmd(2'b01, 3'b000, 1'b0, 4'h7, 1'b0, 1'b0, lat);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("midrst_acc", {28'b0, rsp_data}, 32'd0);
    check("midrst_cf", {31'b0, rsp_cf}, 32'd0);
    check("midrst_zf", {31'b0, rsp_zf}, 32'd0);
    check("midrst_count", {24'b0, op_count}, 32'd0);

    // Backpressure: response held while a READ waits
    do_cmd(2'b01, 3'b000, 1'b0, 4'h5, 1'b0, 1'b0, lat);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_kind  = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rsp_data", {28'b0, rsp_data}, 32'h5);
      check("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("release_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("release_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("read_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("read_data", {28'b0, rsp_data}, 32'h5);
    finish_rsp();

    // Counter saturation over 260 EXECs
    for (int i = 0; i < 254; i++) begin
      exec_add(4'h1, 1'b0, 1'b0);
      finish_rsp();
    end
    check("count_254", {24'b0, op_count}, 32'd254);
    exec_add(4'h1, 1'b0, 1'b0);
    finish_rsp();
    check("count_255", {24'b0, op_count}, 32'd255);
    for (int i = 0; i < 5; i++) begin
      exec_add(4'h1, 1'b0, 1'b0);
      finish_rsp();
    end
    check("count_saturated", {24'b0, op_count}, 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
- Command-driven accumulator sequencer that sits directly upstream of the combinational 4-bit alu.
- It presents registered operands (accumulator as A, command operand as B), op, mode and c_in to the alu.
- It captures the alu result and carry back into the accumulator and flags, then returns a response over a valid/ready handshake.
- This turns the combinational alu into a multi-step, carry-chaining datapath stage.

Parameters:
- WIDTH, 4, datapath width; must match the alu operand width.
- CNT_W, 8, width of the executed-operation counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_kind  in  2  command kind: 00 EXEC, 01 LOAD, 10 CLRF, 11 READ.
- cmd_op  in  3  alu operation code; used by EXEC only.
- cmd_mode  in  1  alu mode, 0 = logic, 1 = arithmetic; used by EXEC only.
- cmd_operand  in  WIDTH  B operand for EXEC; load value for LOAD.
- cmd_use_cf  in  1  1: alu c_in = carry flag; 0: alu c_in = cmd_cin.
- cmd_cin  in  1  explicit carry-in.
- alu_a  out  WIDTH  to alu A.
- alu_b  out  WIDTH  to alu B.
- alu_c_in  out  1  to alu c_in.
- alu_mode  out  1  to alu mode.
- alu_op  out  3  to alu op.
- alu_out  in  WIDTH  from alu out.
- alu_c_out  in  1  from alu c_out.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  accumulator value.
- rsp_cf  out  1  carry flag.
- rsp_zf  out  1  zero flag.
- op_count  out  CNT_W  number of completed EXEC commands; saturates at all-ones.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- On reset:
  - state goes to IDLE.
  - acc, cf, zf and op_count go to 0.
  - Operand, op and mode registers go to 0.
  - rsp_valid = 0, cmd_ready = 1.
  - alu_* outputs = 0.
- Reset mid-operation (EXEC or RESP) aborts the operation immediately; the pending response is dropped.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept (cmd_valid & cmd_ready), latch op, mode, operand and the resolved c_in. The resolved c_in uses the cf value held at that cycle.
  - EXEC kind: go to EXEC.
  - LOAD kind: acc <= operand, zf <= (operand == 0), cf unchanged; go to RESP.
  - CLRF kind: cf <= 0, acc and zf unchanged; go to RESP.
  - READ kind: no state change; go to RESP.
- EXEC (exactly one cycle):
  - alu_a = acc, alu_b = latched operand, alu_op, alu_mode and alu_c_in come from the latched registers. All are registers, so the alu inputs are stable for the whole cycle.
  - At the end of the cycle: acc <= alu_out, zf <= (alu_out == 0).
  - cf <= alu_c_out only if the latched mode == 1. In logic mode, cf is preserved and alu_c_out is ignored.
  - op_count increments, saturating at 2^CNT_W-1.
  - Next state: RESP.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_cf and rsp_zf reflect the updated acc, cf and zf. They hold stable until the handshake completes.
  - cmd_ready = 0.
  - When rsp_ready = 1, go to IDLE; the next command can be accepted the cycle after.
- Latency from accept (cycle 0):
  - EXEC: rsp_valid asserted in cycle 2.
  - LOAD, CLRF, READ: rsp_valid asserted in cycle 1.
- Throughput: at most one command in flight; there is no command/response overlap.
- alu_* outputs hold their last values outside EXEC. Only results sampled in EXEC affect state.
- cmd_* inputs are don't-care when the command is not accepted.
- Arithmetic results wrap modulo 2^WIDTH. The carry is carried only through cf, which enables multi-nibble chaining via cmd_use_cf = 1.
- rsp_ready held high in IDLE has no effect.
- cmd_valid asserted during EXEC or RESP waits, since cmd_ready = 0. The requester must hold the command until it is accepted.

Decomposition:
- Shared package alu_pkg holds:
  - cmd_kind constants (KIND_EXEC, KIND_LOAD, KIND_CLRF, KIND_READ).
  - mode constants (MODE_LOGIC, MODE_ARITH).
  - FSM state encodings.
  - WIDTH default.
- No sub-module is needed; the alu is instantiated alongside this block, not inside it.
- The bench pairs this block with the existing alu. Where alu op semantics matter, the bench uses a stub with these definitions:
  - mode 1 / op 000: A+B+c_in.
  - mode 0 / op 000: A & B.

Test Plan:
- Reset with rst=1 for 2 cycles, driven in the middle of a RESP → rsp_valid=0, cmd_ready=1, acc=0, cf=0, zf=0, op_count=0 on the next edge.
- LOAD 4'hA, then EXEC mode 1 op 000 operand 4'h3, cmd_cin 0 → rsp_data=4'hD, rsp_cf=0, rsp_zf=0, rsp_valid exactly 2 cycles after accept, op_count=1.
- LOAD 4'hF, EXEC add operand 4'h1, cin 0 → rsp_data=4'h0, rsp_cf=1, rsp_zf=1. Follow with EXEC add operand 4'h0, cmd_use_cf=1 → rsp_data=4'h1, rsp_cf=0.
- With cf=1, EXEC mode 0 op 000 operand 4'h5 on acc 4'hA → rsp_data=4'h0, rsp_zf=1, rsp_cf stays 1. Then CLRF → rsp_cf=0, rsp_data=4'h0.
- Hold rsp_ready=0 for 5 cycles while cmd_valid=1 → rsp_valid and rsp_data stable, cmd_ready=0 throughout. Next command accepted only the cycle after rsp_ready rises.
- 260 consecutive EXEC commands with CNT_W=8 → op_count saturates at 255 and does not wrap.
